// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, applies stall/redirect/halt
// priority, and holds the IF/ID pipeline register handed to the decode stage.
module fetch_stage #(
  parameter logic [31:0] PC_INIT     = 32'hFFFFFFFC,
  parameter logic [31:0] BUBBLE      = 32'h00000000,
  parameter logic [5:0]  SENTINEL_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        pre_start;
  logic        sentinel;

  assign redir     = jump | branch_taken;
  assign target    = (jump ? jump_target : branch_target) & ~32'h3;
  assign pc_plus4  = pc_q + 32'd4;
  // While pc sits at PC_INIT the memory word is meaningless, so no halt check.
  assign pre_start = (pc_q == PC_INIT);
  assign sentinel  = (instr_in[31:26] == SENTINEL_OP) && !pre_start;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    count_d  = count_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (halted_q) begin
      // frozen until reset
    end else if (redir) begin
      pc_d    = target;
      instr_d = BUBBLE;
      valid_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (pre_start) begin
      pc_d    = pc_plus4;
      instr_d = BUBBLE;
      valid_d = 1'b0;
    end else if (sentinel) begin
      halted_d = 1'b1;
      instr_d  = BUBBLE;
      valid_d  = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = instr_in;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= PC_INIT;
      instr_q  <= BUBBLE;
      pc4_q    <= 32'd0;
      count_q  <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign halted         = halted_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];
  int          n_vec;
  int          n_err;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: address -4 and anything out of range reads as sentinel
  always_comb begin
    instr_in = 32'hFC000000;
    if (pc != 32'hFFFFFFFC && pc < 32'd256) instr_in = mem[pc[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".pc4"}, if_id_pc_plus4, e_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check({tag, ".count"}, fetch_count, e_cnt);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    stall = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hFC000000;
    mem[0] = 32'h20080001;
    mem[1] = 32'h20090002;
    mem[2] = 32'h01095020;
    mem[3] = 32'hFC000000;

    // straight-line program, reset values checked before any clock edge
    rst = 1'b1;
    #3;
    check_ifid("rst0", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 32'd0);
    check("rst0.halted", {31'd0, halted}, 32'd0);
    step();
    rst = 1'b0;
    check("prestart.pc", pc, 32'hFFFFFFFC);
    step(); check_ifid("start", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); check_ifid("sl0", 32'h4, 32'h20080001, 32'h4, 1'b1, 32'd1);
    step(); check_ifid("sl1", 32'h8, 32'h20090002, 32'h8, 1'b1, 32'd2);
    step(); check_ifid("sl2", 32'hC, 32'h01095020, 32'hC, 1'b1, 32'd3);
    step(); check_ifid("halt", 32'hC, 32'h0, 32'hC, 1'b0, 32'd3);
    check("halt.halted", {31'd0, halted}, 32'd1);
    jump = 1'b1; jump_target = 32'h0;
    step(); check_ifid("halt_jmp", 32'hC, 32'h0, 32'hC, 1'b0, 32'd3);
    check("halt_jmp.halted", {31'd0, halted}, 32'd1);
    jump = 1'b0;

    // second program: distinct words, sentinel planted at 0x44
    for (int i = 0; i < 64; i++) mem[i] = 32'h20000000 + i;
    mem[17] = 32'hFC000000;
    rst = 1'b1;
    #2;
    check("rst1.halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    step(); check("p2.pc", pc, 32'h0);
    step(); check_ifid("p2a", 32'h4, 32'h20000000, 32'h4, 1'b1, 32'd1);

    stall = 1'b1;
    step(); check_ifid("stall1", 32'h4, 32'h20000000, 32'h4, 1'b1, 32'd1);
    step(); check_ifid("stall2", 32'h4, 32'h20000000, 32'h4, 1'b1, 32'd1);
    stall = 1'b0;
    step(); check_ifid("resume", 32'h8, 32'h20000001, 32'h8, 1'b1, 32'd2);

    branch_taken = 1'b1; branch_target = 32'h20;
    step(); check_ifid("br", 32'h20, 32'h0, 32'h8, 1'b0, 32'd2);
    branch_taken = 1'b0;
    step(); check_ifid("br_tgt", 32'h24, 32'h20000008, 32'h24, 1'b1, 32'd3);

    jump = 1'b1; jump_target = 32'h40;
    branch_taken = 1'b1; branch_target = 32'h20;
    stall = 1'b1;
    step(); check_ifid("jmp_win", 32'h40, 32'h0, 32'h24, 1'b0, 32'd3);
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    step(); check_ifid("jmp_tgt", 32'h44, 32'h20000010, 32'h44, 1'b1, 32'd4);

    jump = 1'b1; jump_target = 32'h43;
    step(); check_ifid("align", 32'h40, 32'h0, 32'h44, 1'b0, 32'd4);
    jump = 1'b0;
    step(); check_ifid("align_tgt", 32'h44, 32'h20000010, 32'h44, 1'b1, 32'd5);

    // sentinel on the wrong path must not halt when a branch is taken
    branch_taken = 1'b1; branch_target = 32'h10;
    step(); check_ifid("sent_br", 32'h10, 32'h0, 32'h44, 1'b0, 32'd5);
    check("sent_br.halted", {31'd0, halted}, 32'd0);
    branch_taken = 1'b0;
    step(); check_ifid("sent_tgt", 32'h14, 32'h20000004, 32'h14, 1'b1, 32'd6);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check_ifid("async_rst", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 32'd0);
    check("async_rst.halted", {31'd0, halted}, 32'd0);
    #1;
    rst = 1'b0;
    step(); check("post_rst.pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
